// File: rtl/trans_status_ipa.sv
// Per-SID outstanding-transfer tracker: grants allocations while a SID's counter has room,
// flags SIDs going idle, and latches the first completion seen for an idle SID.
module trans_status_ipa #(
  parameter int unsigned TRANS_SID_WIDTH = 2,
  parameter int unsigned CNT_WIDTH       = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       alloc_req_i,
  input  logic [TRANS_SID_WIDTH-1:0] alloc_sid_i,
  output logic                       alloc_gnt_o,
  input  logic                       synch_req_i,
  input  logic [TRANS_SID_WIDTH-1:0] synch_sid_i,
  output logic [(1<<TRANS_SID_WIDTH)-1:0] busy_o,
  output logic                       evt_valid_o,
  output logic [TRANS_SID_WIDTH-1:0] evt_sid_o,
  output logic                       err_o,
  output logic [TRANS_SID_WIDTH-1:0] err_sid_o,
  input  logic                       err_clr_i
);

  localparam int unsigned NSID = 1 << TRANS_SID_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CMax = '1;

  logic [CNT_WIDTH-1:0]       cnt_q [NSID];
  logic [CNT_WIDTH-1:0]       cnt_d [NSID];
  logic [NSID-1:0]            busy_q, busy_d;
  logic                       evt_valid_q, evt_valid_d;
  logic [TRANS_SID_WIDTH-1:0] evt_sid_q, evt_sid_d;
  logic                       err_q, err_d;
  logic [TRANS_SID_WIDTH-1:0] err_sid_q, err_sid_d;

  logic same_sid, gnt, alloc_acc, cancel, synch_dec, synch_err;

  always_comb begin
    same_sid  = (alloc_sid_i == synch_sid_i);
    // A same-SID completion frees a slot this cycle, so a full counter may still grant.
    gnt       = (cnt_q[alloc_sid_i] != CMax) || (synch_req_i && same_sid);
    alloc_acc = alloc_req_i && gnt;
    // Same-SID allocation and completion cancel out: no count change, event or error.
    cancel    = alloc_acc && synch_req_i && same_sid;
    synch_dec = synch_req_i && !cancel && (cnt_q[synch_sid_i] != '0);
    synch_err = synch_req_i && !cancel && (cnt_q[synch_sid_i] == '0);
  end

  assign alloc_gnt_o = gnt;

  always_comb begin
    for (int unsigned k = 0; k < NSID; k++) begin
      cnt_d[k] = cnt_q[k];
      if (alloc_acc && !cancel && (alloc_sid_i == TRANS_SID_WIDTH'(k))) begin
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end else if (synch_dec && (synch_sid_i == TRANS_SID_WIDTH'(k))) begin
        cnt_d[k] = cnt_q[k] - CNT_WIDTH'(1);
      end
      busy_d[k] = (cnt_d[k] != '0);
    end
  end

  always_comb begin
    evt_valid_d = synch_dec && (cnt_q[synch_sid_i] == CNT_WIDTH'(1));
    evt_sid_d   = evt_valid_d ? synch_sid_i : evt_sid_q;

    err_d     = err_q;
    err_sid_d = err_sid_q;
    if (err_clr_i) begin
      err_d     = 1'b0;
      err_sid_d = '0;
    end
    // Only the first offender is kept; a clear in the same cycle re-arms capture.
    if (synch_err && (!err_q || err_clr_i)) begin
      err_d     = 1'b1;
      err_sid_d = synch_sid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NSID; k++) begin
        cnt_q[k] <= '0;
      end
      busy_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_sid_q   <= '0;
      err_q       <= 1'b0;
      err_sid_q   <= '0;
    end else begin
      for (int unsigned k = 0; k < NSID; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      busy_q      <= busy_d;
      evt_valid_q <= evt_valid_d;
      evt_sid_q   <= evt_sid_d;
      err_q       <= err_d;
      err_sid_q   <= err_sid_d;
    end
  end

  assign busy_o      = busy_q;
  assign evt_valid_o = evt_valid_q;
  assign evt_sid_o   = evt_sid_q;
  assign err_o       = err_q;
  assign err_sid_o   = err_sid_q;

endmodule

// File: tb/tb_trans_status_ipa.sv
// Directed bench for trans_status_ipa with default parameters (4 SIDs, 3-bit counters).
module tb_trans_status_ipa;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       alloc_req_i;
  logic [1:0] alloc_sid_i;
  logic       alloc_gnt_o;
  logic       synch_req_i;
  logic [1:0] synch_sid_i;
  logic [3:0] busy_o;
  logic       evt_valid_o;
  logic [1:0] evt_sid_o;
  logic       err_o;
  logic [1:0] err_sid_o;
  logic       err_clr_i;

  int n_checks = 0;
  int n_errors = 0;

  trans_status_ipa #(
    .TRANS_SID_WIDTH(2),
    .CNT_WIDTH      (3)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .alloc_req_i(alloc_req_i),
    .alloc_sid_i(alloc_sid_i),
    .alloc_gnt_o(alloc_gnt_o),
    .synch_req_i(synch_req_i),
    .synch_sid_i(synch_sid_i),
    .busy_o     (busy_o),
    .evt_valid_o(evt_valid_o),
    .evt_sid_o  (evt_sid_o),
    .err_o      (err_o),
    .err_sid_o  (err_sid_o),
    .err_clr_i  (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req_i = 1'b0;
    synch_req_i = 1'b0;
    err_clr_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    alloc_sid_i = 2'd0;
    synch_sid_i = 2'd0;
    idle_inputs();
    tick();
    tick();
    rst_i = 1'b0;
    n_checks++; if (busy_o !== 4'b0000) begin n_errors++; $display("FAIL reset_busy: got %b want 0000", busy_o); end
    n_checks++; if (evt_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_evt: got %b want 0", evt_valid_o); end
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    for (int s = 0; s < 4; s++) begin
      alloc_sid_i = 2'(s);
      #1;
      n_checks++; if (alloc_gnt_o !== 1'b1) begin n_errors++; $display("FAIL reset_gnt sid%0d: got %b want 1", s, alloc_gnt_o); end
    end
  endtask

  task automatic test_drain();
    alloc_req_i = 1'b1; alloc_sid_i = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (busy_o !== 4'b0100) begin n_errors++; $display("FAIL drain_alloc%0d busy: got %b want 0100", i, busy_o); end
    end
    alloc_req_i = 1'b0;
    synch_req_i = 1'b1; synch_sid_i = 2'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (busy_o !== 4'b0100 || evt_valid_o !== 1'b0) begin n_errors++; $display("FAIL drain_cmpl%0d: got busy=%b evt=%b want busy=0100 evt=0", i, busy_o, evt_valid_o); end
    end
    tick();
    synch_req_i = 1'b0;
    n_checks++; if (evt_valid_o !== 1'b1 || evt_sid_o !== 2'd2) begin n_errors++; $display("FAIL drain_evt: got evt=%b sid=%0d want evt=1 sid=2", evt_valid_o, evt_sid_o); end
    n_checks++; if (busy_o !== 4'b0000) begin n_errors++; $display("FAIL drain_busy_idle: got %b want 0000", busy_o); end
    tick();
    n_checks++; if (evt_valid_o !== 1'b0 || evt_sid_o !== 2'd2) begin n_errors++; $display("FAIL drain_evt_pulse: got evt=%b sid=%0d want evt=0 sid=2", evt_valid_o, evt_sid_o); end
  endtask

  task automatic test_saturate();
    alloc_req_i = 1'b1; alloc_sid_i = 2'd1;
    for (int i = 0; i < 7; i++) tick();
    alloc_req_i = 1'b0;
    #1;
    n_checks++; if (alloc_gnt_o !== 1'b0) begin n_errors++; $display("FAIL sat_gnt_full: got %b want 0", alloc_gnt_o); end
    alloc_sid_i = 2'd0;
    #1;
    n_checks++; if (alloc_gnt_o !== 1'b1) begin n_errors++; $display("FAIL sat_gnt_other: got %b want 1", alloc_gnt_o); end
    alloc_req_i = 1'b1; alloc_sid_i = 2'd1;
    synch_req_i = 1'b1; synch_sid_i = 2'd1;
    #1;
    n_checks++; if (alloc_gnt_o !== 1'b1) begin n_errors++; $display("FAIL sat_gnt_bypass: got %b want 1", alloc_gnt_o); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (alloc_gnt_o !== 1'b0 || evt_valid_o !== 1'b0 || busy_o !== 4'b0010) begin n_errors++; $display("FAIL sat_hold7: got gnt=%b evt=%b busy=%b want gnt=0 evt=0 busy=0010", alloc_gnt_o, evt_valid_o, busy_o); end
    synch_req_i = 1'b1; synch_sid_i = 2'd1;
    for (int i = 0; i < 7; i++) tick();
    synch_req_i = 1'b0;
    n_checks++; if (evt_valid_o !== 1'b1 || evt_sid_o !== 2'd1 || busy_o !== 4'b0000) begin n_errors++; $display("FAIL sat_drain: got evt=%b sid=%0d busy=%b want evt=1 sid=1 busy=0000", evt_valid_o, evt_sid_o, busy_o); end
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL sat_no_err: got %b want 0", err_o); end
  endtask

  task automatic test_same_sid();
    alloc_req_i = 1'b1; alloc_sid_i = 2'd0;
    tick();
    synch_req_i = 1'b1; synch_sid_i = 2'd0;
    tick();
    idle_inputs();
    n_checks++; if (evt_valid_o !== 1'b0 || busy_o !== 4'b0001) begin n_errors++; $display("FAIL same_sid: got evt=%b busy=%b want evt=0 busy=0001", evt_valid_o, busy_o); end
    synch_req_i = 1'b1; synch_sid_i = 2'd0;
    tick();
    synch_req_i = 1'b0;
    n_checks++; if (evt_valid_o !== 1'b1 || evt_sid_o !== 2'd0 || busy_o !== 4'b0000) begin n_errors++; $display("FAIL same_sid_count1: got evt=%b sid=%0d busy=%b want evt=1 sid=0 busy=0000", evt_valid_o, evt_sid_o, busy_o); end
  endtask

  task automatic test_err();
    synch_req_i = 1'b1; synch_sid_i = 2'd3;
    tick();
    n_checks++; if (err_o !== 1'b1 || err_sid_o !== 2'd3) begin n_errors++; $display("FAIL err_first: got err=%b sid=%0d want err=1 sid=3", err_o, err_sid_o); end
    n_checks++; if (evt_valid_o !== 1'b0 || busy_o !== 4'b0000) begin n_errors++; $display("FAIL err_no_evt: got evt=%b busy=%b want evt=0 busy=0000", evt_valid_o, busy_o); end
    synch_sid_i = 2'd1;
    tick();
    n_checks++; if (err_o !== 1'b1 || err_sid_o !== 2'd3) begin n_errors++; $display("FAIL err_sticky: got err=%b sid=%0d want err=1 sid=3", err_o, err_sid_o); end
    synch_req_i = 1'b0; err_clr_i = 1'b1;
    tick();
    n_checks++; if (err_o !== 1'b0 || err_sid_o !== 2'd0) begin n_errors++; $display("FAIL err_clear: got err=%b sid=%0d want err=0 sid=0", err_o, err_sid_o); end
    err_clr_i = 1'b0;
    synch_req_i = 1'b1; synch_sid_i = 2'd2;
    tick();
    synch_sid_i = 2'd1; err_clr_i = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (err_o !== 1'b1 || err_sid_o !== 2'd1) begin n_errors++; $display("FAIL err_clr_prio: got err=%b sid=%0d want err=1 sid=1", err_o, err_sid_o); end
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL err_clear2: got %b want 0", err_o); end
  endtask

  task automatic test_reset_mid();
    alloc_req_i = 1'b1;
    alloc_sid_i = 2'd0; tick(); tick();
    alloc_sid_i = 2'd1; tick();
    alloc_sid_i = 2'd3; tick(); tick(); tick();
    n_checks++; if (busy_o !== 4'b1011) begin n_errors++; $display("FAIL mid_busy: got %b want 1011", busy_o); end
    // Leave an allocation and a completion in flight while resetting.
    alloc_sid_i = 2'd2;
    synch_req_i = 1'b1; synch_sid_i = 2'd0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    idle_inputs();
    n_checks++; if (busy_o !== 4'b0000 || evt_valid_o !== 1'b0 || evt_sid_o !== 2'd0 || err_o !== 1'b0 || err_sid_o !== 2'd0) begin n_errors++; $display("FAIL mid_reset_out: got busy=%b evt=%b esid=%0d err=%b rsid=%0d want all 0", busy_o, evt_valid_o, evt_sid_o, err_o, err_sid_o); end
    for (int s = 0; s < 4; s++) begin
      alloc_sid_i = 2'(s);
      #1;
      n_checks++; if (alloc_gnt_o !== 1'b1) begin n_errors++; $display("FAIL mid_gnt sid%0d: got %b want 1", s, alloc_gnt_o); end
    end
    synch_req_i = 1'b1; synch_sid_i = 2'd3;
    tick();
    synch_req_i = 1'b0;
    n_checks++; if (err_o !== 1'b1 || err_sid_o !== 2'd3) begin n_errors++; $display("FAIL mid_err: got err=%b sid=%0d want err=1 sid=3", err_o, err_sid_o); end
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    alloc_req_i = 1'b1; alloc_sid_i = 2'd3;
    tick();
    alloc_sid_i = 2'd0;
    synch_req_i = 1'b1; synch_sid_i = 2'd3;
    tick();
    idle_inputs();
    n_checks++; if (busy_o !== 4'b0001 || evt_valid_o !== 1'b1 || evt_sid_o !== 2'd3) begin n_errors++; $display("FAIL cross_sid: got busy=%b evt=%b sid=%0d want busy=0001 evt=1 sid=3", busy_o, evt_valid_o, evt_sid_o); end
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL cross_no_err: got %b want 0", err_o); end
    synch_req_i = 1'b1; synch_sid_i = 2'd0;
    tick();
    synch_req_i = 1'b0;
    n_checks++; if (busy_o !== 4'b0000 || evt_sid_o !== 2'd0) begin n_errors++; $display("FAIL cross_drain: got busy=%b sid=%0d want busy=0000 sid=0", busy_o, evt_sid_o); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_saturate();
    test_same_sid();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
